// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM pin-level responder.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam logic [SRAM_DATA_W-1:0] SRAM_POISON = 16'hDEAD;

  localparam int LAT_CNT_W = 4;
  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

  localparam logic [15:0] STAT_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == STAT_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_responder_mem.sv
// Single-port backing store, registered read, no reset so it maps onto block RAM.
// Read data reflects the address presented on the previous edge (1-cycle latency).
module sram_responder_mem #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Pin-level async SRAM (IS62WV25616-style) responder with programmable read latency.
// SRAM_BIT13_FAULT_EN: forces data bit 13 low on writes and on the read bus.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] POISON = SRAM_POISON
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_pins,
  input  logic [DATA_W-1:0] data_pins_in,
  output logic [DATA_W-1:0] data_pins_out,
  output logic              data_pins_out_en,
  input  logic              OE,
  input  logic              WE,
  input  logic              CS,
  input  logic              stat_clear,
  output logic [15:0]       write_count,
  output logic [15:0]       read_count,
  output logic              proto_error
);

`ifdef SRAM_BIT13_FAULT_EN
  localparam logic [DATA_W-1:0] DATA_MASK = ~(DATA_W'(1) << 13);
`else
  localparam logic [DATA_W-1:0] DATA_MASK = '1;
`endif

  localparam lat_cnt_t LAT_MAX = lat_cnt_t'(READ_LATENCY);

  logic              run;
  logic              wr;
  logic              rd;
  logic              prev_wr;
  logic [ADDR_W-1:0] prev_addr;
  logic              viol;
  lat_cnt_t          lat_cnt;
  lat_cnt_t          lat_nxt;
  logic              lat_hit;
  logic [DATA_W-1:0] rdata;

  // run stays low through the reset-release edge so a write sampled there is dropped
  assign wr = ~CS & ~WE & run;
  assign rd = ~CS & ~OE & WE;

  assign data_pins_out_en = rd & reset_n;

  assign viol = wr & (~OE | (prev_wr & (address_pins != prev_addr)));

  always_comb begin
    lat_nxt = '0;
    if (rd && (address_pins == prev_addr))
      lat_nxt = (lat_cnt == LAT_MAX) ? LAT_MAX : lat_cnt + lat_cnt_t'(1);
  end

  assign lat_hit = (lat_nxt == LAT_MAX) && (lat_cnt != LAT_MAX);

  sram_responder_mem #(
    .AW (MEM_AW),
    .DW (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .addr  (address_pins[MEM_AW-1:0]),
    .wdata (data_pins_in & DATA_MASK),
    .rdata (rdata)
  );

  assign data_pins_out = ((lat_cnt == LAT_MAX) ? rdata : POISON) & DATA_MASK;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      prev_wr     <= 1'b0;
      prev_addr   <= '0;
      lat_cnt     <= '0;
      write_count <= '0;
      read_count  <= '0;
      proto_error <= 1'b0;
    end else begin
      run       <= 1'b1;
      prev_wr   <= wr;
      prev_addr <= address_pins;
      lat_cnt   <= lat_nxt;

      if (stat_clear) begin
        write_count <= '0;
        read_count  <= '0;
      end else begin
        if (wr && !prev_wr) write_count <= sat_inc(write_count);
        if (lat_hit)        read_count  <= sat_inc(read_count);
      end

      // a violation on the clearing edge must still be recorded
      if (viol)            proto_error <= 1'b1;
      else if (stat_clear) proto_error <= 1'b0;
    end
  end

endmodule
